multi_debouncer: RTL and testbench

- Parametrised, multi-channel successor to the single-button debouncer.
- Each of CHANNELS raw button/switch inputs is qualified independently. Each channel reports:
  - a debounced level
  - one-cycle press, release and auto-repeat pulses
  - a long-hold flag
- Sits between the board push-button/switch pins and the UI/game control logic.
- The act output is the drop-in equivalent of the legacy single "out" pulse.

---
 rtl/multi_debouncer_if.sv | 12 +
 rtl/multi_debouncer.sv | 110 +++++++++++
 tb/tb_multi_debouncer.sv | 89 ++++++++
 3 files changed

// File: rtl/multi_debouncer_if.sv
// multi_debouncer_if: raw button inputs and qualified per-channel event outputs.
interface multi_debouncer_if #(parameter int CHANNELS = 4);
    logic [CHANNELS-1:0] in_i;
    logic [CHANNELS-1:0] level_o;
    logic [CHANNELS-1:0] press_o;
    logic [CHANNELS-1:0] release_o;
    logic [CHANNELS-1:0] repeat_o;
    logic [CHANNELS-1:0] long_hold_o;
    logic [CHANNELS-1:0] act_o;
    modport master(output in_i, input level_o, press_o, release_o, repeat_o, long_hold_o, act_o);
    modport slave(input in_i, output level_o, press_o, release_o, repeat_o, long_hold_o, act_o);
endinterface

// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel debounce with press/release/auto-repeat pulses and long-hold flag.
// Define MULTI_DEBOUNCER_SYNC_EN to insert a 2-flop synchronizer on every raw input.
module multi_debouncer #(
    parameter int CHANNELS = 4,
    parameter int PRESS_CLOCK_THR = 500000,
    parameter int RELEASE_CLOCK_THR = 500000,
    parameter int LONG_PRESS_THR = 25000000,
    parameter int CONTINUOUS_PRESS_THR = 5000000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW = '0
) (
    input logic clk,
    input logic rst,
    multi_debouncer_if.slave bus
);
    localparam int M1 = PRESS_CLOCK_THR > RELEASE_CLOCK_THR ? PRESS_CLOCK_THR : RELEASE_CLOCK_THR;
    localparam int M2 = LONG_PRESS_THR > CONTINUOUS_PRESS_THR ? LONG_PRESS_THR : CONTINUOUS_PRESS_THR;
    localparam int MAXT = M1 > M2 ? M1 : M2;
    localparam int CW = MAXT > 1 ? $clog2(MAXT) : 1;
    localparam logic [CW-1:0] P_LAST = CW'(PRESS_CLOCK_THR - 1);
    localparam logic [CW-1:0] R_LAST = CW'(RELEASE_CLOCK_THR - 1);
    localparam logic [CW-1:0] L_LAST = CW'(LONG_PRESS_THR - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CONTINUOUS_PRESS_THR - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT, REL_WAIT} state_e;

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] level, press, rel, rpt, long_hold;

`ifdef MULTI_DEBOUNCER_SYNC_EN
    // Synchronizer idles at the inactive level so reset never looks like a press.
    logic [CHANNELS-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= bus.in_i;
            sync2_q <= sync1_q;
        end
    end
    assign s = sync2_q ^ ACTIVE_LOW;
`else
    assign s = bus.in_i ^ ACTIVE_LOW;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_e state_q, state_d, prev_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic long_q, long_d, s_prev_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                prev_q <= IDLE;
                cnt_q <= '0;
                long_q <= 1'b0;
                s_prev_q <= 1'b0;
            end else begin
                state_q <= state_d;
                prev_q <= state_q;
                cnt_q <= cnt_d;
                long_q <= long_d;
                s_prev_q <= s[c];
            end
        end
        always_comb begin
            state_d = state_q;
            cnt_d = '0;
            long_d = long_q;
            case (state_q)
                IDLE: begin
                    if (s[c]) begin
                        if (cnt_q == P_LAST) state_d = HELD;
                        else cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s[c]) state_d = REL_WAIT;
                    else if (cnt_q == L_LAST) begin
                        state_d = REPEAT;
                        long_d = 1'b1;
                    end else cnt_d = cnt_q + 1'b1;
                end
                REPEAT: begin
                    if (!s[c]) state_d = REL_WAIT;
                    else if (cnt_q != C_LAST) cnt_d = cnt_q + 1'b1;
                end
                default: begin
                    if (s[c]) state_d = long_q ? REPEAT : HELD;
                    else if (cnt_q == R_LAST) begin
                        state_d = IDLE;
                        long_d = 1'b0;
                    end else cnt_d = cnt_q + 1'b1;
                end
            endcase
        end
        // Pulses key off the previous state so a bounce back from REL_WAIT stays silent.
        assign level[c] = state_q != IDLE;
        assign long_hold[c] = state_q == REPEAT;
        assign press[c] = state_q == HELD && prev_q == IDLE;
        assign rel[c] = state_q == IDLE && prev_q == REL_WAIT;
        assign rpt[c] = state_q == REPEAT && cnt_q == '0 && s_prev_q && prev_q != REL_WAIT;
    end

    assign bus.level_o = level;
    assign bus.press_o = press;
    assign bus.release_o = rel;
    assign bus.repeat_o = rpt;
    assign bus.long_hold_o = long_hold;
    assign bus.act_o = press | rpt;
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed cycle-by-cycle checks of multi_debouncer with small thresholds.
module tb_multi_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    multi_debouncer_if #(.CHANNELS(4)) a();
    multi_debouncer_if #(.CHANNELS(4)) b();

    multi_debouncer #(.CHANNELS(4), .PRESS_CLOCK_THR(4), .RELEASE_CLOCK_THR(4),
        .LONG_PRESS_THR(10), .CONTINUOUS_PRESS_THR(3), .ACTIVE_LOW(4'b0000))
        dut_a (.clk(clk), .rst(rst), .bus(a));
    multi_debouncer #(.CHANNELS(4), .PRESS_CLOCK_THR(4), .RELEASE_CLOCK_THR(4),
        .LONG_PRESS_THR(10), .CONTINUOUS_PRESS_THR(3), .ACTIVE_LOW(4'b0010))
        dut_b (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: got %b expected %b", tag, k, got, exp);
        end
    endtask

    // Check cycle k's registered outputs, drive cycle k's input, advance one clock.
    task automatic cyc(input bit sel, input string tag, input int k, input logic [3:0] iv,
                       input logic [3:0] el, input logic [3:0] ep, input logic [3:0] er,
                       input logic [3:0] et, input logic [3:0] eh);
        if (sel) b.in_i = iv;
        else a.in_i = iv;
        chk({tag, ".level"}, k, sel ? b.level_o : a.level_o, el);
        chk({tag, ".press"}, k, sel ? b.press_o : a.press_o, ep);
        chk({tag, ".release"}, k, sel ? b.release_o : a.release_o, er);
        chk({tag, ".repeat"}, k, sel ? b.repeat_o : a.repeat_o, et);
        chk({tag, ".long_hold"}, k, sel ? b.long_hold_o : a.long_hold_o, eh);
        chk({tag, ".act"}, k, sel ? b.act_o : a.act_o, ep | et);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a.in_i = 4'b0000;
        b.in_i = 4'b0010;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        a.in_i = 4'b0000;
        b.in_i = 4'b0010;
        do_reset();
        chk("reset.level", 0, a.level_o, 4'b0000);
        chk("reset.act", 0, a.act_o, 4'b0000);
        for (int k = 0; k < 28; k++)
            cyc(0, "hold", k, 4'(k < 20), 4'(k >= 4 && k <= 24), 4'(k == 4), 4'(k == 25),
                4'(k == 14 || k == 17 || k == 20), 4'(k >= 14 && k <= 20));
        do_reset();
        for (int k = 0; k < 12; k++)
            cyc(0, "bounce", k, 4'(k < 8 && k != 3 && k != 7), 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        do_reset();
        for (int k = 0; k < 22; k++)
            cyc(0, "glitch", k, 4'(k != 6 && k != 7), 4'(k >= 4), 4'(k == 4), 4'b0,
                4'(k == 19), 4'(k >= 19));
        do_reset();
        for (int k = 0; k < 8; k++)
            cyc(0, "simul", k, 4'b0101, k >= 4 ? 4'b0101 : 4'b0000, k == 4 ? 4'b0101 : 4'b0000,
                4'b0, 4'b0, 4'b0);
        do_reset();
        for (int k = 0; k < 15; k++)
            cyc(0, "midrst", k, 4'b0001, 4'(k >= 4), 4'(k == 4), 4'b0, 4'(k == 14), 4'(k >= 14));
        rst = 1'b1;
        cyc(0, "midrst", 15, 4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0001);
        rst = 1'b0;
        for (int k = 16; k < 23; k++)
            cyc(0, "midrst", k, 4'b0001, 4'(k >= 20), 4'(k == 20), 4'b0, 4'b0, 4'b0);
        do_reset();
        for (int k = 0; k < 18; k++)
            cyc(1, "polarity", k, (k >= 5 && k <= 10) ? 4'b0000 : 4'b0010,
                (k >= 9 && k <= 15) ? 4'b0010 : 4'b0000, k == 9 ? 4'b0010 : 4'b0000,
                k == 16 ? 4'b0010 : 4'b0000, 4'b0, 4'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
